tdm_demux4: RTL and testbench

//   Receive-side 1:4 time-division demultiplexer: the far end of a 4:1 mux link.

---
 rtl/tdm_demux4.sv | 102 ++++++++++
 tb/tb_tdm_demux4.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM demultiplexer: gathers slots 0..3 into shadow regs, publishes a full frame at once.
// Latency: ch0..ch3/frame_valid update one cycle after the slot-3 beat.
// Backpressure: none; din_valid=0 simply holds all state, gaps of any length are transparent.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      slot        <= 2'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow0 <= din;
              slot    <= 2'd1;
              state   <= LOCKED;
              locked  <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync anywhere but slot 0 restarts the frame; the partial frame is dropped.
              if (slot != 2'd0) sync_err <= 1'b1;
              shadow0 <= din;
              slot    <= 2'd1;
            end else begin
              case (slot)
                2'd0: begin
                  sync_err <= 1'b1;
                  state    <= HUNT;
                  locked   <= 1'b0;
                  slot     <= 2'd0;
                end
                2'd1: begin
                  shadow1 <= din;
                  slot    <= 2'd2;
                end
                2'd2: begin
                  shadow2 <= din;
                  slot    <= 2'd3;
                end
                default: begin
                  ch0         <= shadow0;
                  ch1         <= shadow1;
                  ch2         <= shadow2;
                  ch3         <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, mid-frame reset sequence, then random beats against a queue model.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [0:0] ch0, ch1, ch2, ch3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just the list of samples collected since the last sync.
  logic m_q[$];
  logic m_locked;
  logic m_ch[4];
  logic m_fv, m_err;

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    for (int i = 0; i < 4; i++) m_ch[i] = 1'b0;
    m_fv = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic d);
    m_fv = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s) begin
        m_err = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  // Called at 1 time unit after a rising edge; returns at the same phase of the next edge.
  task automatic apply(input logic v, input logic s, input logic d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ch"}, {28'd0, ch0, ch1, ch2, ch3}, {28'd0, m_ch[0], m_ch[1], m_ch[2], m_ch[3]});
    check({tag, ".frame_valid"}, {31'd0, frame_valid}, {31'd0, m_fv});
    check({tag, ".slot"}, {30'd0, slot}, m_q.size());
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, m_locked});
    check({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, m_err});
  endtask

  typedef struct {
    logic       v, s, d;
    logic [3:0] ch;     // {ch0,ch1,ch2,ch3}
    logic       fv;
    logic [1:0] sl;
    logic       lk, er;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic v, s, d, input logic [3:0] ch, input logic fv,
                     input logic [1:0] sl, input logic lk, er);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.ch = ch; t.fv = fv; t.sl = sl; t.lk = lk; t.er = er;
    vec.push_back(t);
  endtask

  initial begin
    //   v  s  d  ch0..3    fv slot lk er
    // frame 1,0,1,0 with a gap
    add(1, 1, 1, 4'b0000, 0, 2'd1, 1, 0);
    add(1, 0, 0, 4'b0000, 0, 2'd2, 1, 0);
    add(0, 0, 1, 4'b0000, 0, 2'd2, 1, 0);
    add(1, 0, 1, 4'b0000, 0, 2'd3, 1, 0);
    add(1, 0, 0, 4'b1010, 1, 2'd0, 1, 0);
    add(0, 0, 0, 4'b1010, 0, 2'd0, 1, 0);
    // back-to-back frame 1,1,0,0
    add(1, 1, 1, 4'b1010, 0, 2'd1, 1, 0);
    add(1, 0, 1, 4'b1010, 0, 2'd2, 1, 0);
    add(1, 0, 0, 4'b1010, 0, 2'd3, 1, 0);
    add(1, 0, 0, 4'b1100, 1, 2'd0, 1, 0);
    // missing sync at slot 0
    add(1, 0, 1, 4'b1100, 0, 2'd0, 0, 1);
    // hunting: three beats dropped, then frame 0,1,1,1
    add(1, 0, 1, 4'b1100, 0, 2'd0, 0, 0);
    add(1, 0, 1, 4'b1100, 0, 2'd0, 0, 0);
    add(1, 0, 0, 4'b1100, 0, 2'd0, 0, 0);
    add(1, 1, 0, 4'b1100, 0, 2'd1, 1, 0);
    add(1, 0, 1, 4'b1100, 0, 2'd2, 1, 0);
    add(0, 0, 0, 4'b1100, 0, 2'd2, 1, 0);
    add(1, 0, 1, 4'b1100, 0, 2'd3, 1, 0);
    add(1, 0, 1, 4'b0111, 1, 2'd0, 1, 0);
    // early sync at slot 3, then a fresh frame 1,0,1,1
    add(1, 1, 1, 4'b0111, 0, 2'd1, 1, 0);
    add(1, 0, 0, 4'b0111, 0, 2'd2, 1, 0);
    add(1, 0, 0, 4'b0111, 0, 2'd3, 1, 0);
    add(1, 1, 1, 4'b0111, 0, 2'd1, 1, 1);
    add(1, 0, 0, 4'b0111, 0, 2'd2, 1, 0);
    add(1, 0, 1, 4'b0111, 0, 2'd3, 1, 0);
    add(1, 0, 1, 4'b1011, 1, 2'd0, 1, 0);

    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    #3;
    check("reset.outputs", {24'd0, ch0, ch1, ch2, ch3, frame_valid, slot, locked, sync_err}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vec.size(); i++) begin
      apply(vec[i].v, vec[i].s, vec[i].d);
      check($sformatf("vec%0d.ch", i), {28'd0, ch0, ch1, ch2, ch3}, {28'd0, vec[i].ch});
      check($sformatf("vec%0d.frame_valid", i), {31'd0, frame_valid}, {31'd0, vec[i].fv});
      check($sformatf("vec%0d.slot", i), {30'd0, slot}, {30'd0, vec[i].sl});
      check($sformatf("vec%0d.locked", i), {31'd0, locked}, {31'd0, vec[i].lk});
      check($sformatf("vec%0d.sync_err", i), {31'd0, sync_err}, {31'd0, vec[i].er});
    end

    // Reset two beats into a frame, between clock edges.
    apply(1, 1, 1);
    apply(1, 0, 1);
    rst_n = 1'b0;
    din_valid = 1'b0;
    model_reset();
    #1;
    check("midreset.outputs", {24'd0, ch0, ch1, ch2, ch3, frame_valid, slot, locked, sync_err}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    apply(1, 0, 1);
    check_model("midreset.post_hunt");
    apply(1, 1, 1);
    apply(1, 0, 1);
    apply(0, 0, 0);
    apply(1, 0, 0);
    apply(1, 0, 1);
    check("midreset.frame_ch", {28'd0, ch0, ch1, ch2, ch3}, 32'h0000_000d);
    check("midreset.frame_valid", {31'd0, frame_valid}, 32'd1);
    check_model("midreset.frame");

    // Random beats: mostly well-framed, with occasional misplaced or missing syncs.
    for (int n = 0; n < 3000; n++) begin
      logic v, s, d, nat;
      v   = ($urandom % 4) != 0;
      nat = (m_q.size() == 0);
      s   = (($urandom % 10) == 0) ? ~nat : nat;
      d   = $urandom % 2;
      apply(v, s, d);
      check_model($sformatf("rnd%0d", n));
      if (frame_valid && sync_err) check("rnd.fv_err_exclusive", 32'd1, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
